// File: rtl/inst_encoder_if.sv
// Request and instruction-memory write bundle for inst_encoder.
// The master side issues requests and observes the memory write port.
interface inst_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder writing encoded words sequentially into instruction memory.
// Optional macro ENC_IMM_CHECK_EN rejects requests whose immediate does not fit its field.
module inst_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    inst_encoder_if.slave     bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_SH = 3'd6;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IALU = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [4:0]        op_q;
    logic [4:0]        rd_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [31:0]       imm_q;
    logic [ADDR_W-1:0] held_addr;
    logic [31:0]       held_wdata;

    logic [2:0]        fmt;
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic              op_ok;
    logic              legal;
    logic [31:0]       word;
    logic              we;

    // Opcode decode: instruction format plus the fixed opcode/funct fields.
    always_comb begin
        fmt   = FMT_R;
        opc   = OPC_R;
        f3    = 3'b000;
        f7    = 7'b0000000;
        op_ok = 1'b1;
        case (op_q)
            5'd0:  f3 = 3'b000;
            5'd1:  begin f3 = 3'b000; f7 = F7_ALT; end
            5'd2:  f3 = 3'b111;
            5'd3:  f3 = 3'b110;
            5'd4:  f3 = 3'b100;
            5'd5:  f3 = 3'b001;
            5'd6:  f3 = 3'b101;
            5'd7:  begin f3 = 3'b101; f7 = F7_ALT; end
            5'd8:  begin fmt = FMT_I; opc = OPC_IALU; f3 = 3'b000; end
            5'd9:  begin fmt = FMT_I; opc = OPC_IALU; f3 = 3'b111; end
            5'd10: begin fmt = FMT_I; opc = OPC_IALU; f3 = 3'b110; end
            5'd11: begin fmt = FMT_I; opc = OPC_IALU; f3 = 3'b100; end
            5'd12: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b010; end
            5'd13: begin fmt = FMT_S; opc = OPC_STOR; f3 = 3'b010; end
            5'd14: begin fmt = FMT_B; opc = OPC_BR;   f3 = 3'b000; end
            5'd15: begin fmt = FMT_B; opc = OPC_BR;   f3 = 3'b001; end
            5'd16: begin fmt = FMT_B; opc = OPC_BR;   f3 = 3'b100; end
            5'd17: begin fmt = FMT_B; opc = OPC_BR;   f3 = 3'b101; end
            5'd18: begin fmt = FMT_U; opc = OPC_LUI; end
            5'd19: begin fmt = FMT_J; opc = OPC_JAL; end
            5'd20: begin fmt = FMT_I;  opc = OPC_JALR; f3 = 3'b000; end
            5'd21: begin fmt = FMT_SH; opc = OPC_IALU; f3 = 3'b001; end
            5'd22: begin fmt = FMT_SH; opc = OPC_IALU; f3 = 3'b101; end
            5'd23: begin fmt = FMT_SH; opc = OPC_IALU; f3 = 3'b101; f7 = F7_ALT; end
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        word = '0;
        case (fmt)
            FMT_R:  word = {f7, rs2_q, rs1_q, f3, rd_q, opc};
            FMT_I:  word = {imm_q[11:0], rs1_q, f3, rd_q, opc};
            FMT_S:  word = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opc};
            FMT_B:  word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3,
                            imm_q[4:1], imm_q[11], opc};
            FMT_U:  word = {imm_q[31:12], 5'b00000 | rd_q, opc};
            FMT_J:  word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opc};
            FMT_SH: word = {f7, imm_q[4:0], rs1_q, f3, rd_q, opc};
            default: word = '0;
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    logic imm_ok;

    // An immediate fits when every bit above the field's sign bit repeats it.
    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S: imm_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
            FMT_B:        imm_ok = ((&imm_q[31:12]) | ~(|imm_q[31:12])) & ~imm_q[0];
            FMT_J:        imm_ok = ((&imm_q[31:20]) | ~(|imm_q[31:20])) & ~imm_q[0];
            FMT_SH:       imm_ok = ~(|imm_q[31:5]);
            FMT_U:        imm_ok = ~(|imm_q[11:0]);
            default:      imm_ok = 1'b1;
        endcase
    end

    assign legal = op_ok & imm_ok;
`else
    assign legal = op_ok;
`endif

    // Write strobe is gated by flush in the same cycle so an abort suppresses it.
    assign we           = (state == WRITE) && legal && !flush;
    assign bus.imem_we  = we;
    assign bus.imem_addr  = we ? count[ADDR_W-1:0] : held_addr;
    assign bus.imem_wdata = we ? word : held_wdata;
    assign bus.in_ready = (state == IDLE) && !flush;
    assign full         = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            err        <= 1'b0;
            held_addr  <= '0;
            held_wdata <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.in_op;
                        rd_q  <= bus.in_rd;
                        rs1_q <= bus.in_rs1;
                        rs2_q <= bus.in_rs2;
                        imm_q <= bus.in_imm;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (legal) begin
                        held_addr  <= count[ADDR_W-1:0];
                        held_wdata <= word;
                        count      <= count + ONE;
                        state      <= (count == LAST) ? FULL : IDLE;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                FULL:    state <= FULL;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized scoreboard bench for inst_encoder with a table-driven RV32I reference model.
// A driver predicts every write into a queue; a negedge monitor pops and compares.
module tb_inst_encoder;

    localparam int AW = 2;
    localparam int unsigned DEPTH = 1 << AW;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    inst_encoder_if #(.ADDR_W(AW)) bus ();

    inst_encoder #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count),
        .full  (full),
        .err   (err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    int unsigned m_count  = 0;
    bit          m_full   = 0;
    bit          m_err    = 0;
    bit          m_busy   = 0;
    bit          p_legal  = 0;
    logic [31:0] p_data   = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] itype(int unsigned imm12, int unsigned rs1,
                                          int unsigned f3, int unsigned rd, int unsigned opc);
        return 32'((imm12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc);
    endfunction

    function automatic logic [31:0] ref_word(int unsigned op, int unsigned rd, int unsigned rs1,
                                             int unsigned rs2, logic [31:0] imm);
        int unsigned r_f3 [8] = '{0, 0, 7, 6, 4, 1, 5, 5};
        int unsigned i_f3 [4] = '{0, 7, 6, 4};
        int unsigned b_f3 [4] = '{0, 1, 4, 5};
        int unsigned s_f3 [3] = '{1, 5, 5};
        int unsigned u = imm;
        int unsigned f7;
        if (op <= 7) begin
            f7 = (op == 1 || op == 7) ? 32 : 0;
            return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (r_f3[op] << 12) | (rd << 7) | 'h33);
        end
        if (op <= 11) return itype(u % 4096, rs1, i_f3[op-8], rd, 'h13);
        if (op == 12) return itype(u % 4096, rs1, 2, rd, 'h03);
        if (op == 13)
            return 32'((((u >> 5) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                       | ((u % 32) << 7) | 'h23);
        if (op <= 17)
            return 32'((((u >> 12) % 2) << 31) | (((u >> 5) % 64) << 25) | (rs2 << 20)
                       | (rs1 << 15) | (b_f3[op-14] << 12) | (((u >> 1) % 16) << 8)
                       | (((u >> 11) % 2) << 7) | 'h63);
        if (op == 18) return 32'((u / 4096 * 4096) | (rd << 7) | 'h37);
        if (op == 19)
            return 32'((((u >> 20) % 2) << 31) | (((u >> 1) % 1024) << 21)
                       | (((u >> 11) % 2) << 20) | (((u >> 12) % 256) << 12) | (rd << 7) | 'h6F);
        if (op == 20) return itype(u % 4096, rs1, 0, rd, 'h67);
        f7 = (op == 23) ? 32 : 0;
        return 32'((f7 << 25) | ((u % 32) << 20) | (rs1 << 15) | (s_f3[op-21] << 12) | (rd << 7) | 'h13);
    endfunction

    function automatic bit ref_legal(int unsigned op, logic [31:0] imm);
`ifdef ENC_IMM_CHECK_EN
        int si = int'($signed(imm));
`endif
        if (op > 23) return 1'b0;
`ifdef ENC_IMM_CHECK_EN
        if (op inside {8, 9, 10, 11, 12, 13, 20}) return (si >= -2048) && (si <= 2047);
        if (op inside {[14:17]}) return (si >= -4096) && (si <= 4095) && !imm[0];
        if (op == 19) return (si >= -(1 << 20)) && (si < (1 << 20)) && !imm[0];
        if (op >= 21) return imm < 32;
        if (op == 18) return imm[11:0] == 12'h000;
`endif
        return 1'b1;
    endfunction

    // One clock of stimulus, entered and left one time unit after a rising edge.
    task automatic step(input bit v, input int unsigned op, input int unsigned rd,
                        input int unsigned rs1, input int unsigned rs2, input logic [31:0] imm,
                        input bit fl, input bit use_lit, input logic [31:0] lit);
        bit ready_exp;
        check("count", 32'(count), m_count);
        check("full", 32'(full), 32'(m_full));
        check("err", 32'(err), 32'(m_err));
        bus.in_valid = v;
        bus.in_op    = op[4:0];
        bus.in_rd    = rd[4:0];
        bus.in_rs1   = rs1[4:0];
        bus.in_rs2   = rs2[4:0];
        bus.in_imm   = imm;
        flush        = fl;
        #1;
        ready_exp = !m_busy && !m_full && !fl;
        check("in_ready", 32'(bus.in_ready), 32'(ready_exp));
        if (fl) begin
            m_count = 0; m_full = 0; m_err = 0; m_busy = 0;
        end else if (m_busy) begin
            if (p_legal) begin
                exp_q.push_back('{addr: 32'(m_count), data: p_data});
                m_count++;
                if (m_count == DEPTH) m_full = 1;
            end else begin
                m_err = 1;
            end
            m_busy = 0;
        end else if (v && ready_exp) begin
            m_busy  = 1;
            p_legal = ref_legal(op, imm);
            p_data  = use_lit ? lit : ref_word(op, rd, rs1, rs2, imm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0, 0, 0, '0);
    endtask

    task automatic do_flush();
        step(0, 0, 0, 0, 0, '0, 1, 0, '0);
    endtask

    task automatic req(input int unsigned op, input int unsigned rd, input int unsigned rs1,
                       input int unsigned rs2, input logic [31:0] imm,
                       input bit use_lit, input logic [31:0] lit);
        step(1, op, rd, rs1, rs2, imm, 0, use_lit, lit);
        idle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_addr = '0;
            last_data = '0;
        end else if (bus.imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_addr), e.addr);
                check("wr_data", bus.imem_wdata, e.data);
                last_addr = e.addr;
                last_data = e.data;
            end
        end else begin
            check("hold_addr", 32'(bus.imem_addr), last_addr);
            check("hold_data", bus.imem_wdata, last_data);
        end
    end

    initial begin
        int unsigned op;
        logic [31:0] imm;
        bus.in_valid = 0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_imm = '0;
        flush = 0;
        rst_n = 1;
        #2 rst_n = 0;
        #2;
        check("rst_we", 32'(bus.imem_we), 0);
        check("rst_addr", 32'(bus.imem_addr), 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_err", 32'(err), 0);
        @(negedge clk);
        #2 rst_n = 1;

        req(0, 1, 2, 3, '0, 1, 32'h003100B3);
        req(1, 5, 6, 7, '0, 1, 32'h407302B3);
        req(13, 0, 2, 8, 32'hFFFF_FFFC, 1, 32'hFE812E23);
        do_flush();
        req(25, 1, 2, 3, '0, 0, '0);
        idle();
        do_flush();
`ifdef ENC_IMM_CHECK_EN
        req(8, 1, 0, 0, 32'd2048, 0, '0);
`else
        req(8, 1, 0, 0, 32'd2048, 1, 32'h80000093);
`endif
        do_flush();

        for (int i = 0; i < 4; i++) req(0, i + 1, 2, 3, '0, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 9, 9, 9, '0, 0, 0, '0);
        do_flush();
        req(4, 3, 4, 5, '0, 0, '0);

        step(1, 2, 7, 8, 9, '0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0, 1, 0, '0);
        idle();

        step(1, 0, 1, 2, 3, '0, 0, 0, '0);
        rst_n = 0;
        #1;
        check("rstw_we", 32'(bus.imem_we), 0);
        check("rstw_addr", 32'(bus.imem_addr), 0);
        check("rstw_wdata", bus.imem_wdata, 0);
        check("rstw_count", 32'(count), 0);
        check("rstw_full", 32'(full), 0);
        check("rstw_err", 32'(err), 0);
        m_count = 0; m_full = 0; m_err = 0; m_busy = 0;
        bus.in_valid = 0;
        @(negedge clk);
        #2 rst_n = 1;
        req(0, 1, 2, 3, '0, 1, 32'h003100B3);

        for (int i = 0; i < 800; i++) begin
            op = ($urandom % 8 == 0) ? 24 + $urandom % 8 : $urandom % 24;
            case ($urandom % 4)
                0: imm = 32'($urandom_range(0, 31)) - 32'd16;
                1: imm = $urandom;
                2: imm = ($urandom % 4096) << 12;
                default: imm = $urandom % 32;
            endcase
            step($urandom % 4 != 0, op, $urandom % 32, $urandom % 32, $urandom % 32, imm,
                 $urandom % 20 == 0, 0, '0);
        end
        idle();
        idle();
        idle();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
